ahb_param_slave: RTL and testbench
==================================

# ahb_param_slave

Parametrised AHB memory slave with pseudo-random wait states. It is the next-generation bench and integration target for bus masters such as the file-reader master. It generalises the generic slave in data width, storage depth and delay range, and adds byte-lane writes, write-to-read forwarding and an optional ERROR response. It sits behind the system address decoder, which drives its HSEL. It never initiates transfers.

## Interface
- ADDR_WIDTH, 16, byte-address bits decoded; storage is 2^ADDR_WIDTH bytes.
- DATA_WIDTH, 32, bus width; legal values are 32 or 64.
- MIN_DELAY, 0, minimum wait states per transfer.
- MAX_DELAY, 3, maximum wait states per transfer; must be ≥ MIN_DELAY and ≤ 15.
- LFSR_SEED, 16'hACE1, reset value of the delay LFSR; must be non-zero.
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address; only bits [ADDR_WIDTH-1:0] are used.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 of the byte count.
- HBURST, HPROT  in  3, 4  accepted but ignored.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY_in  in  1  bus-level HREADY, used to qualify the address phase.
- HRDATA  out  DATA_WIDTH  read data.
- HREADY  out  1  data-phase completion.
- HRESP  out  2  OKAY=00, ERROR=01.

## Operation
- **Address-phase accept:** HSEL & HREADY_in & HTRANS[1]. IDLE and BUSY transfers get a zero-wait OKAY and cause no access.
- **On accept:**
  - Latch address, size and direction.
  - Load the wait counter with MIN_DELAY + (lfsr mod (MAX_DELAY-MIN_DELAY+1)).
  - Advance the LFSR one step (Galois, taps x^16+x^14+x^13+x^11+1). The LFSR advances only on accept.
- **FSM states:**
  - IDLE: accept → WAIT if count > 0, otherwise stay in IDLE with a zero-wait completion.
  - WAIT: decrement each cycle; at 0, drive HREADY=1 and either go to IDLE or take a new accept.
  - ERR1 → ERR2 → IDLE.
- **Writes:** commit on the completing data-phase edge (HREADY=1). Only the byte lanes selected by HSIZE and the low address bits are written.
- **Reads:** storage is read on the address-accept edge. HRDATA holds the full bus word; lane selection is done by the master.
- **Forwarding:** if a write completes on the same edge a read is accepted to the same word, the read returns the merged (new) bytes.
- **Address range:** address wraps modulo 2^ADDR_WIDTH.
- **Size:** HSIZE greater than log2(DATA_WIDTH/8) is illegal; see Configuration.
- **Reset values:**
  - HREADY=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, lfsr=LFSR_SEED.
  - Storage is not reset.
  - Reset during WAIT aborts the transfer with no write.

## Timing
- Data phase lasts count+1 cycles: HREADY=0 for count cycles, then 1.
- HRDATA is valid only while HREADY=1 and HRESP=OKAY.
- Back-to-back pipelined transfers are required: a new accept in the completing cycle incurs no idle cycle.
- ERROR response is two cycles: (HREADY=0, HRESP=ERROR), then (HREADY=1, HRESP=ERROR).
- A master that drives IDLE during ERR2 must be handled without issue.

## Configuration
- Macro: `AHB_PARAM_SLAVE_ERR_EN`.
- **Defined:** unaligned (HADDR not aligned to HSIZE) or oversize transfers take the two-cycle ERROR response. There is no storage write, no wait states, and the LFSR still advances.
- **Undefined:** the same accesses complete with OKAY and normal delay. Misaligned low address bits are forced to the size alignment; oversize transfers are treated as full-width.

## Structure
- **Shared package `ahb_pkg`:**
  - htrans_t, hresp_t, hsize_t enums.
  - OKAY/ERROR and IDLE/BUSY/NONSEQ/SEQ constants.
  - A byte-strobe function, (hsize, addr_lo) → strobe.
- **Sub-module `ahb_slave_lfsr`:** 16-bit LFSR with seed parameter and advance enable.
- **Storage:** DATA_WIDTH-wide array, inferred in the top.

## Test plan
- **Zero-wait word write/read:** MIN=MAX=0, DATA_WIDTH=32. Write 32'hDEADBEEF @0x0010, then read @0x0010 → HREADY never low; HRDATA=32'hDEADBEEF.
- **Byte lanes:** write byte 8'hA5 @0x0013 over word 32'h00000000 → read returns 32'hA5000000.
- **Fixed delay:** MIN=MAX=3. Single read → exactly 3 cycles of HREADY=0, then HREADY=1 with data.
- **Forwarding:** pipelined write 32'h12345678 @0x20 immediately followed by a read @0x20 → read returns 32'h12345678.
- **Error (macro on):** halfword write @0x0001 → (HREADY=0, ERROR), then (HREADY=1, ERROR); a read @0x0000 afterwards shows unchanged contents. With the macro off, the same write lands at 0x0000 with OKAY.
- **Reset mid-wait:** MIN=MAX=5. Assert HRESETn low on the 2nd wait cycle of a write → HREADY=1 and HRESP=00 immediately; the location holds its old value after re-write-free readback.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and the byte-lane strobe helper used by the
// parametrised memory slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_4W    = 3'd4,
        SIZE_8W    = 3'd5,
        SIZE_16W   = 3'd6,
        SIZE_32W   = 3'd7
    } hsize_t;

    // Lanes covered by a transfer of 2^hsize bytes (hsize <= 3) at addr_lo,
    // with the address rounded down to the size alignment.
    function automatic logic [7:0] byte_strobe(input logic [2:0] hsize, input logic [2:0] addr_lo);
        logic [3:0] n;
        logic [7:0] mask;
        logic [2:0] base;
        n    = 4'd1 << hsize;
        mask = (8'd1 << n) - 8'd1;
        base = addr_lo & ~(n[2:0] - 3'd1);
        return mask << base;
    endfunction

endpackage

// File: rtl/ahb_slave_lfsr.sv
// ahb_slave_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that steps only
// when enabled; supplies the wait-state pattern.
module ahb_slave_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_lfsr <= SEED;
        else if (i_en)
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/ahb_param_slave.sv
// ahb_param_slave: AHB memory slave with pseudo-random wait states, byte-lane
// writes and write-to-read forwarding. Define AHB_PARAM_SLAVE_ERR_EN for ERROR on unaligned/oversize.
module ahb_param_slave
    import ahb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter int          MIN_DELAY  = 0,
    parameter int          MAX_DELAY  = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY_in,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic [1:0]            HRESP
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int WW    = ADDR_WIDTH - LB;
    localparam int RANGE = MAX_DELAY - MIN_DELAY + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                r_state, w_state_nx;
    logic [3:0]            r_cnt, w_cnt_nx, w_delay;
    logic                  r_pend, w_pend_nx;
    logic                  r_write;
    logic [WW-1:0]         r_widx, w_widx;
    logic [NB-1:0]         r_strb, w_strb;
    logic [DATA_WIDTH-1:0] r_rdata, w_rd_merged;
    logic [DATA_WIDTH-1:0] r_mem [2**WW];
    logic [15:0]           w_lfsr;
    logic [7:0]            w_strb8;
    logic [2:0]            w_size;
    logic                  w_ready, w_accept, w_bad, w_done_wr, w_fwd;
    logic                  w_unused;

    ahb_slave_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_en    (w_accept),
        .o_lfsr  (w_lfsr)
    );

    assign w_ready   = (r_state == S_IDLE) || (r_state == S_ERR2) || (r_state == S_WAIT && r_cnt == 4'd0);
    assign w_accept  = HSEL & HREADY_in & HTRANS[1] & w_ready;
    assign w_widx    = HADDR[ADDR_WIDTH-1:LB];
    assign w_size    = (HSIZE > 3'(LB)) ? 3'(LB) : HSIZE;
    assign w_strb8   = byte_strobe(w_size, 3'(HADDR[LB-1:0]));
    assign w_strb    = w_strb8[NB-1:0];
    assign w_delay   = 4'(MIN_DELAY + int'(w_lfsr) % RANGE);
    assign w_done_wr = r_pend & r_write & w_ready;
    assign w_fwd     = w_done_wr && (r_widx == w_widx);
    assign w_unused  = ^{HBURST, HPROT, HADDR[31:ADDR_WIDTH], HTRANS[0], w_strb8};

`ifdef AHB_PARAM_SLAVE_ERR_EN
    assign w_bad = (HSIZE > 3'(LB)) || ((HADDR[2:0] & ((3'd1 << HSIZE) - 3'd1)) != 3'd0);
`else
    assign w_bad = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_pend_nx  = r_pend & ~w_ready;
        case (r_state)
            S_WAIT:  if (r_cnt != 4'd0) w_cnt_nx = r_cnt - 4'd1; else w_state_nx = S_IDLE;
            S_ERR1:  w_state_nx = S_ERR2;
            S_ERR2:  w_state_nx = S_IDLE;
            default: ;
        endcase
        // A new accept is only possible while HREADY is high, so it overrides the idle/completion path.
        if (w_accept) begin
            w_pend_nx  = ~w_bad;
            w_cnt_nx   = w_bad ? 4'd0 : w_delay;
            w_state_nx = w_bad ? S_ERR1 : (w_delay != 4'd0 ? S_WAIT : S_IDLE);
        end
    end

    // Read path sees the bytes of a write completing on the same edge.
    always_comb begin
        w_rd_merged = r_mem[w_widx];
        for (int i = 0; i < NB; i++)
            if (w_fwd && r_strb[i]) w_rd_merged[i*8 +: 8] = HWDATA[i*8 +: 8];
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_pend  <= 1'b0;
            r_write <= 1'b0;
            r_widx  <= '0;
            r_strb  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_pend  <= w_pend_nx;
            if (w_accept) begin
                r_write <= HWRITE;
                r_widx  <= w_widx;
                r_strb  <= w_strb;
            end
            if (w_accept && !HWRITE && !w_bad) r_rdata <= w_rd_merged;
        end

    always_ff @(posedge HCLK)
        if (w_done_wr)
            for (int i = 0; i < NB; i++)
                if (r_strb[i]) r_mem[r_widx][i*8 +: 8] <= HWDATA[i*8 +: 8];

    assign HREADY = w_ready;
    assign HRESP  = (r_state == S_ERR1 || r_state == S_ERR2) ? ERROR : OKAY;
    assign HRDATA = r_rdata;

endmodule

// File: tb/tb_ahb_param_slave.sv
// tb_ahb_param_slave: randomized pipelined AHB master against a byte-array
// reference model with an independent wait-state predictor.
module tb_ahb_param_slave;

    localparam int          MIN_D = 0;
    localparam int          MAX_D = 3;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef AHB_PARAM_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit        vld;
        bit        wr;
        bit [2:0]  sz;
        bit [31:0] addr;
        bit [31:0] data;
    } op_t;

    logic        hclk, hrst_n, hsel, hwrite, hready_in, hready;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int          n_tests, n_fail;
    logic [7:0]  m_mem [0:65535];
    bit   [15:0] m_lfsr;
    op_t         p_op;
    bit          p_vld, p_bad;
    int          p_waits;
    logic [31:0] p_exp;

    assign hready_in = hready;

    ahb_param_slave #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .MIN_DELAY  (MIN_D),
        .MAX_DELAY  (MAX_D),
        .LFSR_SEED  (SEED)
    ) u_dut (
        .HCLK      (hclk),
        .HRESETn   (hrst_n),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HBURST    (hburst),
        .HPROT     (hprot),
        .HWDATA    (hwdata),
        .HREADY_in (hready_in),
        .HRDATA    (hrdata),
        .HREADY    (hready),
        .HRESP     (hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input bit vld, input bit wr, input bit [2:0] sz, input bit [31:0] a, input bit [31:0] d);
        op_t o;
        o.vld = vld; o.wr = wr; o.sz = sz; o.addr = a; o.data = d;
        return o;
    endfunction

    function automatic bit is_bad(input op_t o);
        return ERR_EN && (o.sz > 3'd2 || (o.addr % (32'd1 << o.sz)) != 0);
    endfunction

    function automatic logic [31:0] m_word(input bit [31:0] a);
        bit [15:0] w;
        w = a[15:0] & 16'hFFFC;
        return {m_mem[w + 16'd3], m_mem[w + 16'd2], m_mem[w + 16'd1], m_mem[w]};
    endfunction

    task automatic m_write(input op_t o);
        int        n;
        bit [15:0] base;
        n    = 1 << (o.sz > 3'd2 ? 2 : int'(o.sz));
        base = o.addr[15:0] & ~16'(n - 1);
        for (int b = 0; b < n; b++)
            m_mem[base + 16'(b)] = o.data[((int'(base) + b) % 4) * 8 +: 8];
    endtask

    // Presents op's address phase alongside the previous op's data phase, then
    // checks the previous op once the slave signals completion.
    task automatic xfer(input op_t op);
        int         waits;
        logic [1:0] r0;
        hsel   = op.vld | 1'($urandom_range(0, 1));
        htrans = {op.vld, 1'($urandom_range(0, 1))};
        haddr  = op.addr;
        hwrite = op.wr;
        hsize  = op.sz;
        hwdata = p_op.data;
        waits  = 0;
        r0     = 2'b00;
        forever begin
            @(negedge hclk);
            if (waits == 0) r0 = hresp;
            if (hready) break;
            waits++;
            if (waits > 40) begin
                check("timeout", 32'(waits), 32'd0);
                break;
            end
        end
        if (p_vld) begin
            check("waits", 32'(waits), 32'(p_waits));
            check("resp", 32'(hresp), 32'(p_bad));
            check("resp_first", 32'(r0), 32'(p_bad));
            if (!p_bad && p_op.wr) m_write(p_op);
            if (!p_bad && !p_op.wr) check("rdata", hrdata, p_exp);
        end else begin
            check("idle_waits", 32'(waits), 32'd0);
            check("idle_resp", 32'(hresp), 32'd0);
        end
        p_vld = op.vld;
        p_op  = op;
        if (op.vld) begin
            p_bad   = is_bad(op);
            p_waits = p_bad ? 1 : MIN_D + int'(m_lfsr) % (MAX_D - MIN_D + 1);
            p_exp   = m_word(op.addr);
            m_lfsr  = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
        @(posedge hclk);
        #1;
    endtask

    initial begin
        op_t idle_op;
        idle_op = mk(0, 0, 3'd0, 32'd0, 32'd0);
        n_tests = 0; n_fail = 0;
        m_lfsr  = SEED;
        p_vld   = 1'b0;
        hrst_n  = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize   = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = '0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("rst_hready", 32'(hready), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        @(posedge hclk); #1;
        hrst_n = 1'b1;
        @(posedge hclk); #1;

        for (int a = 0; a < 64; a += 4) xfer(mk(1, 1, 3'd2, 32'(a), 32'd0));
        xfer(idle_op);

        xfer(mk(1, 1, 3'd0, 32'h13, 32'hA5A5_A5A5));
        xfer(idle_op);
        xfer(mk(1, 0, 3'd2, 32'h10, 32'd0));
        xfer(idle_op);
        check("byte_lane", hrdata, 32'hA500_0000);

        xfer(mk(1, 1, 3'd2, 32'h10, 32'hDEAD_BEEF));
        xfer(idle_op);
        xfer(mk(1, 0, 3'd2, 32'h10, 32'd0));
        xfer(idle_op);
        check("word_rw", hrdata, 32'hDEAD_BEEF);

        xfer(mk(1, 1, 3'd2, 32'h20, 32'h1234_5678));
        xfer(mk(1, 0, 3'd2, 32'h20, 32'd0));
        xfer(idle_op);
        check("forward", hrdata, 32'h1234_5678);

        xfer(mk(1, 1, 3'd1, 32'h1, 32'hCAFE_BEEF));
        xfer(idle_op);
        xfer(mk(1, 0, 3'd2, 32'h0, 32'd0));
        xfer(idle_op);
        check("unaligned", hrdata, ERR_EN ? 32'h0000_0000 : 32'h0000_BEEF);

        for (int i = 0; i < 300; i++)
            xfer(mk($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) << 16) | $urandom_range(0, 63), $urandom));
        xfer(idle_op);

        while (MIN_D + int'(m_lfsr) % (MAX_D - MIN_D + 1) < 2) begin
            xfer(mk(1, 0, 3'd2, 32'h0, 32'd0));
            xfer(idle_op);
        end
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
        @(negedge hclk);
        check("rstw_accept", 32'(hready), 32'd1);
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hA5A5_5A5A;
        @(negedge hclk);
        check("rstw_wait1", 32'(hready), 32'd0);
        @(negedge hclk);
        check("rstw_wait2", 32'(hready), 32'd0);
        hrst_n = 1'b0;
        #1;
        check("rstw_hready", 32'(hready), 32'd1);
        check("rstw_hresp", 32'(hresp), 32'd0);
        check("rstw_hrdata", hrdata, 32'd0);
        m_lfsr = SEED;
        p_vld  = 1'b0;
        @(posedge hclk); #1;
        hrst_n = 1'b1;
        @(posedge hclk); #1;
        xfer(mk(1, 0, 3'd2, 32'h30, 32'd0));
        xfer(idle_op);
        check("rstw_keep", hrdata, m_word(32'h30));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
